instruction_memory_loader: RTL and testbench

Boot-time writer for the instruction memory. It receives a byte stream (length header, little-endian instruction words, checksum trailer) and issues one-cycle 32-bit word writes to consecutive byte addresses. It feeds the memory write port that the fetch path later reads asynchronously as {b3,b2,b1,b0}. It runs before the datapath leaves reset and holds status until the next load.

---
 rtl/instruction_memory_loader_pkg.sv | 18 +
 rtl/instruction_memory_loader_byte_word_assembler.sv | 44 ++++
 rtl/instruction_memory_loader.sv | 109 ++++++++++
 tb/tb_instruction_memory_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_memory_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// State encoding and memory geometry used by the loader and its assembler.
package imem_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      CHECK  = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_t;

   localparam int WORD_BYTES = 4;
   localparam int MEM_BYTES  = 256;

endpackage

// File: rtl/instruction_memory_loader_byte_word_assembler.sv
// Packs an accepted byte stream little-endian into 32-bit words.
// The word output register only changes when a word completes, so it holds between writes.
module byte_word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        last,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  byte_idx;
   logic [23:0] partial;

   assign last = (byte_idx == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_idx   <= 2'd0;
         partial    <= 24'd0;
         word       <= 32'd0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            byte_idx <= 2'd0;
         end else if (in_valid) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
               2'd0:    partial[7:0]   <= in_data;
               2'd1:    partial[15:8]  <= in_data;
               2'd2:    partial[23:16] <= in_data;
               default: begin
                  word       <= {in_data, partial};
                  word_valid <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/instruction_memory_loader.sv
// Boot loader: length header, little-endian words, XOR checksum trailer.
// Issues one-cycle word writes one cycle after each word's final byte.
module instruction_memory_loader
   import imem_pkg::*;
#(
   parameter int MAX_WORDS = MEM_BYTES / WORD_BYTES,
   parameter int ADDR_W    = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic [7:0]        rx_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error
);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] base;
   logic [15:0]       count;
   logic [15:0]       word_idx;
   logic [7:0]        csum;
   logic [15:0]       len_full;
   logic              accept;
   logic              start_ok;
   logic              byte_last;
   logic              data_in;

   always_comb begin
      rx_ready = 1'b0;
      if (state == LEN_LO || state == LEN_HI || state == DATA || state == CHECK)
         rx_ready = 1'b1;
   end

   assign accept   = rx_valid && rx_ready;
   assign start_ok = start && (state == IDLE || state == DONE || state == ERR);
   assign len_full = {rx_data, count[7:0]};
   assign data_in  = accept && (state == DATA);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE, ERR: if (start) state_nx = LEN_LO;
         LEN_LO:          if (accept) state_nx = LEN_HI;
         LEN_HI: begin
            if (accept) begin
               if (len_full > 16'(MAX_WORDS)) state_nx = ERR;
               else if (len_full == 16'd0)    state_nx = CHECK;
               else                           state_nx = DATA;
            end
         end
         DATA: if (data_in && byte_last && (word_idx == count - 16'd1)) state_nx = CHECK;
         CHECK: if (accept) state_nx = (rx_data == csum) ? DONE : ERR;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         base     <= '0;
         count    <= 16'd0;
         word_idx <= 16'd0;
         csum     <= 8'd0;
         mem_addr <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx == LEN_LO || state_nx == LEN_HI ||
                   state_nx == DATA   || state_nx == CHECK);
         done  <= (state_nx == DONE);
         error <= (state_nx == ERR);
         // start and byte acceptance never coincide: rx_ready is low wherever start is honoured
         if (start_ok) begin
            base     <= base_addr;
            count    <= 16'd0;
            word_idx <= 16'd0;
            csum     <= 8'd0;
         end
         if (accept && state != CHECK) csum <= csum ^ rx_data;
         if (accept && state == LEN_LO) count[7:0]  <= rx_data;
         if (accept && state == LEN_HI) count[15:8] <= rx_data;
         if (data_in && byte_last) begin
            mem_addr <= base + ADDR_W'(word_idx) * ADDR_W'(WORD_BYTES);
            word_idx <= word_idx + 16'd1;
         end
      end
   end

   byte_word_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (start_ok),
      .in_valid   (data_in),
      .in_data    (rx_data),
      .last       (byte_last),
      .word       (mem_wdata),
      .word_valid (mem_we)
   );

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Scoreboard bench: drivers push expected writes, a negedge monitor pops and compares.
module tb_instruction_memory_loader;

   localparam int ADDR_W = 64;

   logic              clk = 1'b0;
   logic              reset, start, rx_valid;
   logic [ADDR_W-1:0] base_addr;
   logic [7:0]        rx_data;
   logic              rx_ready, mem_we, busy, done, error;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   instruction_memory_loader #(.MAX_WORDS(64), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] data;
      int          at;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr %0h data %0h", mem_addr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", mem_addr, mon_e.addr);
            chk("wr_data", {32'd0, mem_wdata}, {32'd0, mon_e.data});
            chk("wr_latency", 64'(cyc), 64'(mon_e.at));
         end
      end
   end

   task automatic pulse_start(input logic [63:0] b);
      @(negedge clk);
      base_addr = b;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   // Returns the cycle number of the handshake cycle (-1 on timeout).
   task automatic send(input logic [7:0] d, input int gap, output int acc);
      int n = 0;
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = d;
      while (!rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         checks++;
         errors++;
         $display("FAIL rx_ready_timeout byte %0h", d);
         rx_valid = 1'b0;
         acc = -1;
      end else begin
         acc = cyc;
         @(posedge clk);
         #1 rx_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [63:0] addr, input logic [31:0] w, input int gap);
      int  acc;
      wr_t e;
      for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap, acc);
      e.addr = addr;
      e.data = w;
      e.at   = acc + 1;
      exp_q.push_back(e);
   endtask

   task automatic status(input string name, input logic b, input logic d, input logic e);
      @(negedge clk);
      chk({name, "_busy"},  {63'd0, busy},  {63'd0, b});
      chk({name, "_done"},  {63'd0, done},  {63'd0, d});
      chk({name, "_error"}, {63'd0, error}, {63'd0, e});
      chk({name, "_qempty"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      reset = 1'b1; start = 1'b0; rx_valid = 1'b0; base_addr = '0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
      chk("rst_mem_we",   {63'd0, mem_we},   64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_wdata",    {32'd0, mem_wdata}, 64'd0);
      chk("rst_busy",     {63'd0, busy},  64'd0);
      chk("rst_done",     {63'd0, done},  64'd0);
      chk("rst_error",    {63'd0, error}, 64'd0);
      reset = 1'b0;

      // 1: single word at 0x4
      pulse_start(64'h4);
      chk("t1_busy_after_start", {63'd0, busy}, 64'd1);
      send(8'h01, 0, acc); send(8'h00, 0, acc);
      send_word(64'h4, 32'h0000_2083, 0);
      send(8'hA2, 0, acc);
      status("t1", 1'b0, 1'b1, 1'b0);
      chk("t1_addr_hold", mem_addr, 64'h4);
      chk("t1_data_hold", {32'd0, mem_wdata}, 64'h2083);

      // 2: zero length, good then bad trailer
      pulse_start(64'h0);
      chk("t2_done_cleared", {63'd0, done}, 64'd0);
      send(8'h00, 0, acc); send(8'h00, 0, acc); send(8'h00, 0, acc);
      status("t2a", 1'b0, 1'b1, 1'b0);
      pulse_start(64'h0);
      send(8'h00, 0, acc); send(8'h00, 0, acc); send(8'h01, 0, acc);
      status("t2b", 1'b0, 1'b0, 1'b1);

      // 3: oversize header rejected immediately
      pulse_start(64'h0);
      chk("t3_error_cleared", {63'd0, error}, 64'd0);
      send(8'h41, 0, acc); send(8'h00, 0, acc);
      @(negedge clk);
      chk("t3_rx_ready", {63'd0, rx_ready}, 64'd0);
      status("t3", 1'b0, 1'b0, 1'b1);

      // 4: three words with gaps, bad checksum (good would be 0x43)
      pulse_start(64'h0);
      send(8'h03, 1, acc); send(8'h00, 1, acc);
      send_word(64'h0, 32'h1122_3344, 1);
      send_word(64'h4, 32'hAABB_CCDD, 1);
      send_word(64'h8, 32'h0102_0304, 1);
      send(8'h00, 1, acc);
      status("t4", 1'b0, 1'b0, 1'b1);

      // 5: reset in the cycle after the 2nd data byte, then a clean load
      pulse_start(64'h100);
      send(8'h02, 0, acc); send(8'h00, 0, acc);
      send(8'h11, 0, acc); send(8'h22, 0, acc);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_busy_reset", {63'd0, busy}, 64'd0);
      chk("t5_we_reset",   {63'd0, mem_we}, 64'd0);
      reset = 1'b0;
      pulse_start(64'h20);
      send(8'h01, 0, acc); send(8'h00, 0, acc);
      send_word(64'h20, 32'h1234_5678, 0);
      send(8'h09, 0, acc);
      status("t5", 1'b0, 1'b1, 1'b0);

      // 6: start ignored mid-load; start in DONE restarts
      pulse_start(64'h40);
      send(8'h01, 0, acc); send(8'h00, 0, acc);
      send(8'hEF, 0, acc); send(8'hBE, 0, acc);
      pulse_start(64'h999);
      chk("t6_busy_after_ignored", {63'd0, busy}, 64'd1);
      begin
         wr_t e;
         send(8'hAD, 0, acc); send(8'hDE, 0, acc);
         e.addr = 64'h40; e.data = 32'hDEAD_BEEF; e.at = acc + 1;
         exp_q.push_back(e);
      end
      send(8'h23, 0, acc);
      status("t6a", 1'b0, 1'b1, 1'b0);
      pulse_start(64'h0);
      chk("t6_done_cleared", {63'd0, done}, 64'd0);
      chk("t6_busy_restart", {63'd0, busy}, 64'd1);
      send(8'h00, 0, acc); send(8'h00, 0, acc); send(8'h00, 0, acc);
      status("t6b", 1'b0, 1'b1, 1'b0);

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
